i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (responder) for single-master buses: clk-oversampled SCL/SDA, START/STOP detect,
//  7-bit address match, ACK generation, byte-wide write-data output and read-data input.
//  Sits between the SCL/SDA pins and a local register block; peer of i2c_master. No clock stretching.
// PARAMETERS
//  SLAVE_ADDR   7'h50  7-bit bus address this target responds to
//  SYNC_STAGES  2      synchronizer flops on scl/sda inputs (>=2)
// PORTS
//  clk       in     1  system clock; SCL high/low phases must each be >= SYNC_STAGES+2 clk
//  reset     in     1  synchronous, active-high
//  scl       in     1  bus clock (input only, never driven)
//  sda       inout  1  open-drain: driven 1'b0 or 1'bz only, never 1'b1
//  rx_data   out    8  last byte written by master, MSB first on bus
//  rx_valid  out    1  1-clk pulse, rx_data updated same cycle
//  tx_data   in     8  byte to return on a read; must be stable when sampled (see below)
//  tx_req    out    1  1-clk pulse: next read byte is needed
//  rw        out    1  R/W bit of current transfer (1 = master reads)
//  busy      out    1  high from matched address ACK until STOP/START/NACK-to-idle
// BEHAVIOUR
//  - Reset values: sda released (z), rx_data 8'h00, rx_valid 0, tx_req 0, rw 0, busy 0, state IDLE.
//  - scl/sda pass SYNC_STAGES flops, then a 1-flop edge detect; pin-to-event latency SYNC_STAGES+1 clk.
//  - START = sync sda falls while sync scl high; STOP = sync sda rises while sync scl high.
//  - START from ANY state (repeated start included) -> ADDR, bit_cnt=0, sda released.
//  - STOP from ANY state -> IDLE, sda released, busy=0. STOP/START override all other events same clk.
//  - Data sampled on scl rising edge; sda output changed only on scl falling edge.
//  - States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
//    IDLE: wait for START.
//    ADDR: shift 8 bits (7 addr + R/W). On 8th rising edge: match -> latch rw; else -> IGNORE.
//      Matched: on following falling edge drive sda=0 -> ADDR_ACK, busy=1; if rw=1 pulse tx_req.
//    ADDR_ACK: hold sda=0 through 9th clock; on its falling edge: rw=0 -> release sda, WRITE;
//      rw=1 -> load shift reg from tx_data (sampled this clk), drive bit7 (0->0, 1->z), READ.
//    WRITE: shift 8 bits; on 8th rising edge rx_data<=byte, rx_valid pulse; next falling edge
//      drive sda=0 -> WRITE_ACK. WRITE_ACK: release on 9th falling edge -> WRITE (bit_cnt=0).
//    READ: drive next bit on each falling edge; after 8th falling edge release sda -> READ_ACK.
//      Pulse tx_req on 8th rising edge so tx_data is ready >= half SCL period later.
//    READ_ACK: sample sda on 9th rising edge. 0 (ACK): on falling edge load tx_data, drive bit7,
//      -> READ. 1 (NACK): -> IGNORE, busy=0, sda stays released.
//    IGNORE: sda released, no outputs, wait for START/STOP.
//  - bit_cnt 4-bit, wraps 0..8 per byte; byte count unlimited (no internal address pointer).
//  - General call (addr 0) not supported: treated as mismatch.
//  - Reset mid-transfer: immediate return to IDLE, sda released same clk; ignores bus until next START.
// TESTING
//  1. Write 0xA0 (0x50,W) then 0x3C, STOP -> ACK both bytes (sda=0 on 9th clk), rx_data=0x3C,
//     one rx_valid pulse, busy 1->0 at STOP.
//  2. Address 0x51,W -> sda never driven low, no rx_valid, state IGNORE until STOP.
//  3. Read 0xA1, tx_data=0x96 then 0x5A, master ACK then NACK -> bus bits 10010110, 01011010;
//     tx_req pulses 2x (addr-ACK, 8th bit of byte 1); sda released after NACK.
//  4. Write 0xA0,0x11 then repeated START, 0xA1 read -> rx_data=0x11, rw=1, read byte ACKed addr.
//  5. STOP mid-byte after 4 data bits -> IDLE, no rx_valid, sda released within SYNC_STAGES+1 clk.
//  6. reset asserted during READ driving 0 -> sda z next clk, all outputs reset values;
//     following 0xA0 write completes normally.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target with oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wide write-data output and read-data input. SDA is open-drain; no clock stretching.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);
    // state     | meaning
    // IDLE      | bus free, waiting for START
    // ADDR      | shifting address + R/W bit
    // ADDR_ACK  | holding SDA low for the address ACK
    // WRITE     | shifting a byte from the master
    // WRITE_ACK | holding SDA low for the data ACK
    // READ      | driving a byte to the master
    // READ_ACK  | waiting for the master's ACK/NACK
    // IGNORE    | not addressed, waiting for START/STOP
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic sda_low, sda_low_n;
    logic [7:0] rx_data_n;
    logic rx_valid_n, tx_req_n, rw_n, busy_n;

    wire scl_s     = scl_sync[SYNC_STAGES-1];
    wire sda_s     = sda_sync[SYNC_STAGES-1];
    wire scl_rise  = scl_s & ~scl_d;
    wire scl_fall  = ~scl_s & scl_d;
    wire start_det = scl_s & scl_d & sda_d & ~sda_s;
    wire stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    // General call (address 0) is never acknowledged.
    wire addr_hit  = (shift[6:0] == SLAVE_ADDR) && (shift[6:0] != 7'd0);

    // Reset releases the pin combinationally so the bus is freed in the reset cycle.
    assign sda = (sda_low && !reset) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            sda_low  <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            sda_low  <= sda_low_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            rw       <= rw_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        sda_low_n  = sda_low;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        rw_n       = rw;
        busy_n     = busy;
        case (state)
            ADDR: begin
                if (scl_rise) begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (addr_hit) rw_n = sda_s;
                        else          state_n = IGNORE;
                    end
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    sda_low_n = 1'b1;
                    busy_n    = 1'b1;
                    tx_req_n  = rw;
                    state_n   = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (rw) begin
                        shift_n   = tx_data;
                        sda_low_n = ~tx_data[7];
                        bit_cnt_n = 4'd1;
                        state_n   = READ;
                    end else begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (scl_rise) begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        rx_data_n  = {shift[6:0], sda_s};
                        rx_valid_n = 1'b1;
                    end
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    sda_low_n = 1'b1;
                    state_n   = WRITE_ACK;
                end
            end
            WRITE_ACK: begin
                if (scl_fall) begin
                    sda_low_n = 1'b0;
                    bit_cnt_n = 4'd0;
                    state_n   = WRITE;
                end
            end
            READ: begin
                // bit_cnt counts bits already placed on the bus.
                if (scl_rise && bit_cnt == 4'd8) begin
                    tx_req_n = 1'b1;
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = READ_ACK;
                    end else begin
                        sda_low_n = ~shift[6];
                        shift_n   = {shift[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            READ_ACK: begin
                // bit_cnt==8 marks an ACK already seen on the 9th rising edge.
                if (scl_rise) begin
                    if (sda_s) begin
                        busy_n  = 1'b0;
                        state_n = IGNORE;
                    end else begin
                        bit_cnt_n = 4'd8;
                    end
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    shift_n   = tx_data;
                    sda_low_n = ~tx_data[7];
                    bit_cnt_n = 4'd1;
                    state_n   = READ;
                end
            end
            IDLE, IGNORE: ;
            default: state_n = IDLE;
        endcase
        if (stop_det || start_det) begin
            state_n    = stop_det ? IDLE : ADDR;
            bit_cnt_n  = 4'd0;
            sda_low_n  = 1'b0;
            busy_n     = 1'b0;
            rx_valid_n = 1'b0;
            tx_req_n   = 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: behavioural bus master plus scoreboard queues for written
// bytes (checked on rx_valid) and read bytes (supplied on tx_req).
module tb_i2c_slave;
    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda_low;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       rw;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    int txreq_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .rw(rw), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-data monitor: every rx_valid pulse must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_data 0x%0h with nothing expected", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
    end

    // Read-data responder: supplies the next queued byte, or a filler for a prefetch.
    always @(negedge clk) begin
        if (!reset && tx_req) begin
            txreq_cnt++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
            else                 tx_data = 8'hFF;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bit_cycle(input logic b, output logic s);
        #Q m_sda_low = ~b;
        #Q scl = 1'b1;
        #Q s = sda_bus;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_start();
        #Q m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(~ack, s);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sda"}, {31'd0, sda_bus}, 32'd1);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'h00);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_tx_req"}, {31'd0, tx_req}, 32'd0);
        check({tag, "_rw"}, {31'd0, rw}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         c0;

        reset = 1'b1;
        scl = 1'b1;
        m_sda_low = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_reset_values("reset");
        reset = 1'b0;
        #(4*Q);

        // 1: write 0x3C to 0x50
        i2c_start();
        send_byte(8'hA0, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd1);
        check("t1_rw", {31'd0, rw}, 32'd0);
        exp_rx.push_back(8'h3C);
        send_byte(8'h3C, ack);
        check("t1_data_ack", {31'd0, ack}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("t1_busy_stop", {31'd0, busy}, 32'd0);

        // 2: foreign address is never acknowledged
        i2c_start();
        send_byte(8'hA2, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h3C, ack);
        check("t2_data_nack", {31'd0, ack}, 32'd0);
        i2c_stop();

        // 3: read two bytes, ACK then NACK
        c0 = txreq_cnt;
        tx_q.push_back(8'h96);
        tx_q.push_back(8'h5A);
        i2c_start();
        send_byte(8'hA1, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd1);
        check("t3_rw", {31'd0, rw}, 32'd1);
        recv_byte(1'b1, d);
        check("t3_byte1", {24'd0, d}, 32'h96);
        check("t3_tx_req_cnt", txreq_cnt - c0, 32'd2);
        recv_byte(1'b0, d);
        check("t3_byte2", {24'd0, d}, 32'h5A);
        #(2*Q);
        check("t3_sda_released", {31'd0, sda_bus}, 32'd1);
        check("t3_busy_nack", {31'd0, busy}, 32'd0);
        i2c_stop();

        // 4: write then repeated START into a read
        i2c_start();
        send_byte(8'hA0, ack);
        check("t4_waddr_ack", {31'd0, ack}, 32'd1);
        exp_rx.push_back(8'h11);
        send_byte(8'h11, ack);
        check("t4_wdata_ack", {31'd0, ack}, 32'd1);
        tx_q.push_back(8'hC3);
        i2c_start();
        send_byte(8'hA1, ack);
        check("t4_raddr_ack", {31'd0, ack}, 32'd1);
        check("t4_rw", {31'd0, rw}, 32'd1);
        recv_byte(1'b0, d);
        check("t4_rdata", {24'd0, d}, 32'hC3);
        i2c_stop();

        // 5: STOP after four data bits
        i2c_start();
        send_byte(8'hA0, ack);
        check("t5_addr_ack", {31'd0, ack}, 32'd1);
        bit_cycle(1'b0, s);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        bit_cycle(1'b1, s);
        i2c_stop();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_sda", {31'd0, sda_bus}, 32'd1);
        check("t5_rx_data_kept", {24'd0, rx_data}, 32'h11);

        // 6: reset while driving a 0 read bit, then a normal write
        tx_q.push_back(8'h00);
        i2c_start();
        send_byte(8'hA1, ack);
        check("t6_addr_ack", {31'd0, ack}, 32'd1);
        #(Q+20);
        check("t6_sda_driven", {31'd0, sda_bus}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t6_reset");
        reset = 1'b0;
        i2c_start();
        send_byte(8'hA0, ack);
        check("t6_waddr_ack", {31'd0, ack}, 32'd1);
        exp_rx.push_back(8'h77);
        send_byte(8'h77, ack);
        check("t6_wdata_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        #(4*Q);

        check("rx_pending", exp_rx.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
